// File: rtl/panda_compare_unit.sv
// panda_compare_unit
// Registered add/subtract and magnitude compare unit for the Panda integer
// datapath. Each operation takes one cycle: operands enter with valid_i,
// and the sum plus the equal/less flags show up one cycle later with valid_o.
// Outputs come only from registers, so nothing passes combinationally from
// inputs to outputs.

module panda_compare_unit #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             subtract_i,
  input  logic             sign_i,
  output logic [Width-1:0] result_o,
  output logic             is_equal_o,
  output logic             is_less_o,
  output logic             valid_o
);

  localparam int Msb = Width - 1;

  logic [Width-1:0] operand_b_eff;
  logic [Width-1:0] sum;
  logic [Width-1:0] diff;
  logic             is_equal;
  logic             is_less;

  // Adder/subtractor: a + (sub ? ~b : b) + sub; any carry out is dropped.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    operand_b_eff = subtract_i ? ~operand_b_i : operand_b_i;
    sum           = operand_a_i + operand_b_eff + Width'(subtract_i);
  end

  // Comparator: always works from a - b, whatever subtract_i says.
  always_comb begin
    diff     = operand_a_i + ~operand_b_i + Width'(1);
    is_equal = (diff == '0);
    if (operand_a_i[Msb] != operand_b_i[Msb]) begin
      // Opposite MSBs: the sign interpretation alone settles the order.
      // Signed: the negative operand (MSB set) is the smaller one.
      // Unsigned: the operand with MSB set is the larger one.
      is_less = sign_i ? operand_a_i[Msb] : operand_b_i[Msb];
    end else begin
      // Same MSBs: the difference cannot overflow, so its MSB is the borrow.
      is_less = diff[Msb];
    end
  end

  // Output stage: reset clears everything; otherwise capture on valid_i
  // and hold the data when idle.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here, so every register samples the values from before the edge.
    if (rst_i) begin
      result_o   <= '0;
      is_equal_o <= 1'b0;
      is_less_o  <= 1'b0;
      valid_o    <= 1'b0;
    end else if (valid_i) begin
      result_o   <= sum;
      is_equal_o <= is_equal;
      is_less_o  <= is_less;
      valid_o    <= 1'b1;
    end else begin
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_panda_compare_unit.sv
// Self-checking bench for panda_compare_unit (Width = 32). Directed cases
// check against hand-computed constants. Random traffic checks against a
// reference model that uses plain integer arithmetic and comparisons.

module tb_panda_compare_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        subtract_i;
  logic        sign_i;
  logic [31:0] result_o;
  logic        is_equal_o;
  logic        is_less_o;
  logic        valid_o;

  int total = 0;
  int bad   = 0;

  // Expected output registers, kept by the reference model.
  logic [31:0] m_res   = '0;
  logic        m_eq    = 1'b0;
  logic        m_less  = 1'b0;
  logic        m_valid = 1'b0;

  panda_compare_unit #(.Width(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .subtract_i  (subtract_i),
    .sign_i      (sign_i),
    .result_o    (result_o),
    .is_equal_o  (is_equal_o),
    .is_less_o   (is_less_o),
    .valid_o     (valid_o)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, clock them in, and update the model.
  // Returns 1 ns after the rising edge, where the outputs are stable.
  task automatic step(input logic rst, input logic vld, input logic [31:0] a,
                      input logic [31:0] b, input logic sub, input logic sgn);
    longint sa, sb;
    rst_i       = rst;
    valid_i     = vld;
    operand_a_i = a;
    operand_b_i = b;
    subtract_i  = sub;
    sign_i      = sgn;
    @(posedge clk);
    #1;
    if (rst) begin
      m_res = '0; m_eq = 1'b0; m_less = 1'b0; m_valid = 1'b0;
    end else if (vld) begin
      sa      = sgn ? longint'($signed(a)) : longint'(a);
      sb      = sgn ? longint'($signed(b)) : longint'(b);
      m_res   = sub ? (a - b) : (a + b);
      m_eq    = (a == b);
      m_less  = (sa < sb);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    // First reset cycle also carries valid_i=1; reset must win.
    step(1'b1, 1'b1, 32'd5, 32'd3, 1'b1, 1'b0);
    total++;
    if ({result_o, is_equal_o, is_less_o, valid_o} !== {32'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_priority got res=%h eq=%b lt=%b v=%b want all zero",
               result_o, is_equal_o, is_less_o, valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd5, 32'd3, 1'b1, 1'b0);
      total++;
      if ({result_o, is_equal_o, is_less_o, valid_o} !== {32'd0, 3'b000}) begin
        bad++;
        $display("FAIL reset_idle[%0d] got res=%h eq=%b lt=%b v=%b want all zero",
                 i, result_o, is_equal_o, is_less_o, valid_o);
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sgn;
    logic [31:0] res;
    logic        eq;
    logic        lt;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    v[0]  = '{32'd2342,        32'd53493,       1'b1, 1'b0, -32'sd51151, 1'b0, 1'b1};
    v[1]  = '{32'd2342,        32'd53493,       1'b1, 1'b1, -32'sd51151, 1'b0, 1'b1};
    v[2]  = '{-32'sd123,       32'd53493,       1'b1, 1'b0, -32'sd53616, 1'b0, 1'b0};
    v[3]  = '{-32'sd123,       32'd53493,       1'b1, 1'b1, -32'sd53616, 1'b0, 1'b1};
    v[4]  = '{-32'sd123,       -32'sd23423,     1'b1, 1'b1, 32'd23300,   1'b0, 1'b0};
    v[5]  = '{-32'sd123,       -32'sd23423,     1'b1, 1'b0, 32'd23300,   1'b0, 1'b0};
    v[6]  = '{-32'sd23423,     -32'sd23423,     1'b1, 1'b0, 32'd0,       1'b1, 1'b0};
    v[7]  = '{-32'sd23423,     -32'sd23423,     1'b1, 1'b1, 32'd0,       1'b1, 1'b0};
    v[8]  = '{-32'sd23423,     -32'sd23423,     1'b0, 1'b1, -32'sd46846, 1'b1, 1'b0};
    v[9]  = '{32'h8000_0000,   32'h7FFF_FFFF,   1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    v[10] = '{32'h8000_0000,   32'h7FFF_FFFF,   1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[11] = '{32'hFFFF_FFFF,   32'h0000_0002,   1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    // Issued back to back: each cycle must show the previous operation.
    foreach (v[i]) begin
      step(1'b0, 1'b1, v[i].a, v[i].b, v[i].sub, v[i].sgn);
      total++;
      if ({result_o, is_equal_o, is_less_o, valid_o} !== {v[i].res, v[i].eq, v[i].lt, 1'b1}) begin
        bad++;
        $display("FAIL directed[%0d] got res=%h eq=%b lt=%b v=%b want res=%h eq=%b lt=%b v=1",
                 i, result_o, is_equal_o, is_less_o, valid_o, v[i].res, v[i].eq, v[i].lt);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 1'b0);
    total++;
    if ({result_o, is_equal_o, is_less_o, valid_o} !== {32'd93, 3'b001}) begin
      bad++;
      $display("FAIL hold_setup got res=%h eq=%b lt=%b v=%b want res=0000005d eq=0 lt=0 v=1",
               result_o, is_equal_o, is_less_o, valid_o);
    end
    // Idle cycles with changing operands: data must hold, valid_o drops.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
      total++;
      if ({result_o, is_equal_o, is_less_o, valid_o} !== {32'd93, 3'b000}) begin
        bad++;
        $display("FAIL hold_idle[%0d] got res=%h eq=%b lt=%b v=%b want res=0000005d eq=0 lt=0 v=0",
                 i, result_o, is_equal_o, is_less_o, valid_o);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        rst, vld;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = a;
        1:       b = {~a[31], $urandom_range(0, 3) == 0 ? a[30:0] : 31'($urandom)};
        2:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      vld = ($urandom_range(0, 3) != 0);
      step(rst, vld, a, b, 1'($urandom), 1'($urandom));
      total++;
      if ({result_o, is_equal_o, is_less_o, valid_o} !== {m_res, m_eq, m_less, m_valid}) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h got res=%h eq=%b lt=%b v=%b want res=%h eq=%b lt=%b v=%b",
                 i, a, b, result_o, is_equal_o, is_less_o, valid_o, m_res, m_eq, m_less, m_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    // Continuous valid stream: a fresh result must appear every cycle.
    for (int i = 0; i < 50; i++) begin
      a = $urandom;
      b = $urandom;
      step(1'b0, 1'b1, a, b, 1'($urandom), 1'($urandom));
      total++;
      if ({result_o, is_equal_o, is_less_o, valid_o} !== {m_res, m_eq, m_less, 1'b1}) begin
        bad++;
        $display("FAIL back_to_back[%0d] got res=%h eq=%b lt=%b v=%b want res=%h eq=%b lt=%b v=1",
                 i, result_o, is_equal_o, is_less_o, valid_o, m_res, m_eq, m_less);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; operand_a_i = '0; operand_b_i = '0;
    subtract_i = 1'b0; sign_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
